axil_regtest_master: RTL

Synthesizable AXI4-Lite master that performs a self-checking write/read-back sweep over a parametrised bank of slave registers. It replaces the fixed four-register write/read/compare sequence of the simulation-only flow with an on-chip sequencer that has configurable register count, stride, width and data patterns. It sits in front of the freqcalccore S00_AXI slave port, or any AXI4-Lite slave, for board-level bring-up and regression.

---
 rtl/axil_regtest_master.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/axil_regtest_master.sv
// AXI4-Lite master: writes a pattern to each slave register, reads it back, checks it.
// Optional per-channel watchdog: define AXIL_REGTEST_TIMEOUT_EN.
module axil_regtest_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ADDR_STRIDE = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   seed,
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [8:0]                      err_count,
  output logic [7:0]                      fail_idx,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   fail_data,
  output logic                            timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = $clog2(DW);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_READ,
    S_RDATA, S_CHECK, S_DONE
  } state_t;

  state_t          state_q, state_d, nxt;
  logic [1:0]      mode_q;
  logic [DW-1:0]   seed_q;
  logic [7:0]      idx_q;
  logic [AW-1:0]   addr_q;
  logic            aw_ok_q, w_ok_q;
  logic [DW-1:0]   rdata_q;
  logic            rerr_q;
  logic [8:0]      err_q;
  logic [7:0]      fidx_q;
  logic [DW-1:0]   fdata_q;
  logic            failed_q;

  logic            go, last, waiting, to_fire;
  logic            aw_fin, w_fin, chk_bad;
  logic            fail_ev;
  logic [DW-1:0]   fail_val;
  logic [DW-1:0]   sum, pat;

  assign sum = seed_q + DW'(idx_q);

  always_comb begin
    pat = sum;
    unique case (1'b1)
      (mode_q == 2'b01): pat = DW'(1) << idx_q[SW-1:0];
      (mode_q == 2'b10): pat = ~sum;
      default:           pat = sum;
    endcase
  end

  assign go   = start &&
                (state_q == S_IDLE || state_q == S_DONE);
  assign last = (idx_q == 8'(NUM_REGS - 1));

  assign aw_fin  = aw_ok_q | M_AXI_AWREADY;
  assign w_fin   = w_ok_q  | M_AXI_WREADY;
  assign chk_bad = (rdata_q != pat) || rerr_q;

  assign waiting = (state_q == S_WRITE) ||
                   (state_q == S_WRESP) ||
                   (state_q == S_READ)  ||
                   (state_q == S_RDATA);

  always_comb begin
    nxt = state_q;
    unique case (state_q)
      S_IDLE:  if (start) nxt = S_WRITE;
      S_DONE:  if (start) nxt = S_WRITE;
      S_WRITE: if (aw_fin && w_fin) nxt = S_WRESP;
      S_WRESP: if (M_AXI_BVALID) nxt = S_READ;
      S_READ:  if (M_AXI_ARREADY) nxt = S_RDATA;
      S_RDATA: if (M_AXI_RVALID) nxt = S_CHECK;
      S_CHECK: nxt = last ? S_DONE : S_WRITE;
      default: nxt = S_IDLE;
    endcase
  end

  assign state_d = to_fire ? S_DONE : nxt;

  // A bad write response has no read data to report.
  assign fail_ev =
    (state_q == S_WRESP && M_AXI_BVALID &&
     M_AXI_BRESP != 2'b00) ||
    (state_q == S_CHECK && chk_bad);
  assign fail_val =
    (state_q == S_CHECK) ? rdata_q : '0;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      mode_q   <= '0;
      seed_q   <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      aw_ok_q  <= 1'b0;
      w_ok_q   <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
      err_q    <= '0;
      fidx_q   <= '0;
      fdata_q  <= '0;
      failed_q <= 1'b0;
    end else if (go) begin
      mode_q   <= mode;
      seed_q   <= seed;
      idx_q    <= '0;
      addr_q   <= BASE_ADDR;
      aw_ok_q  <= 1'b0;
      w_ok_q   <= 1'b0;
      err_q    <= '0;
      fidx_q   <= '0;
      fdata_q  <= '0;
      failed_q <= 1'b0;
    end else begin
      if (state_q == S_WRITE) begin
        if (M_AXI_AWREADY) aw_ok_q <= 1'b1;
        if (M_AXI_WREADY)  w_ok_q  <= 1'b1;
      end
      if (state_q == S_RDATA && M_AXI_RVALID) begin
        rdata_q <= M_AXI_RDATA;
        rerr_q  <= (M_AXI_RRESP != 2'b00);
      end
      if (fail_ev) begin
        if (err_q != 9'h1FF) err_q <= err_q + 9'd1;
        if (!failed_q) begin
          failed_q <= 1'b1;
          fidx_q   <= idx_q;
          fdata_q  <= fail_val;
        end
      end
      if (state_q == S_CHECK) begin
        aw_ok_q <= 1'b0;
        w_ok_q  <= 1'b0;
        if (!last) begin
          idx_q  <= idx_q + 8'd1;
          addr_q <= addr_q + AW'(ADDR_STRIDE);
        end
      end
    end
  end

`ifdef AXIL_REGTEST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_q;
  logic          to_q;

  // A handshake landing on the last cycle still wins.
  assign to_fire = waiting && (nxt == state_q) &&
                   (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      to_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state_d != state_q)
        to_cnt_q <= '0;
      else if (waiting)
        to_cnt_q <= to_cnt_q + TW'(1);
      if (go)
        to_q <= 1'b0;
      else if (to_fire)
        to_q <= 1'b1;
    end
  end

  assign timeout = to_q;
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  assign busy      = waiting || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0) && !timeout;
  assign err_count = err_q;
  assign fail_idx  = fidx_q;
  assign fail_data = fdata_q;

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = (state_q == S_WRITE) && !aw_ok_q;
  assign M_AXI_WDATA   = pat;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = (state_q == S_WRITE) && !w_ok_q;
  assign M_AXI_BREADY  = (state_q == S_WRESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state_q == S_READ);
  assign M_AXI_RREADY  = (state_q == S_RDATA);

endmodule
